// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Purpose  : Execute stage of the 5-stage RV32I pipeline. Forwards operands
//            from EX/MEM and MEM/WB, runs the ALU, resolves branches and
//            jumps (static not-taken prediction, so every taken transfer
//            raises a same-cycle redirect) and registers the result into
//            the EX/MEM pipeline register.
// Ports    :
//   i_clk, i_reset         clock, synchronous active-low reset
//   i_stall, i_flush       hold / bubble the EX/MEM register, block redirect
//   i_pc .. i_ctrl_op_b_sel  ID/EX pipeline register contents
//   i_wb_en/rd/data        MEM/WB writeback bus (forwarding source)
//   o_redirect(_pc)        taken control transfer and its target
//   o_pc .. o_funct3       EX/MEM pipeline register
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage #(
  parameter int XLEN          = 32,
  parameter int RESET_PC_ZERO = 1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  input  logic [XLEN-1:0] i_imm,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_ctrl_valid,
  input  logic            i_ctrl_bubble,
  input  logic            i_ctrl_kill,
  input  logic            i_ctrl_branch,
  input  logic            i_ctrl_jump,
  input  logic            i_ctrl_mem_read,
  input  logic            i_ctrl_mem_write,
  input  logic            i_ctrl_wb_en,
  input  logic [3:0]      i_ctrl_alu_op,
  input  logic [2:0]      i_ctrl_funct3,
  input  logic [1:0]      i_ctrl_op_a_sel,
  input  logic            i_ctrl_op_b_sel,
  input  logic            i_wb_en,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_alu_result,
  output logic [XLEN-1:0] o_store_data,
  output logic [4:0]      o_rd,
  output logic            o_valid,
  output logic            o_wb_en,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic [2:0]      o_funct3
);

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  // The EX/MEM register is always cleared to zero; the parameter only
  // selects between two equivalent (empty) elaborations.
  generate
    if (RESET_PC_ZERO != 0) begin : g_reset_pc_zero
    end else begin : g_reset_pc_any
    end
  endgenerate

  logic            live;
  logic            exmem_src_ok;
  logic            wb_src_ok;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] result;
  logic [XLEN-1:0] branch_target;
  logic [XLEN-1:0] jump_target;
  logic            cond;
  logic            take;

  assign live = i_ctrl_valid & ~i_ctrl_bubble & ~i_ctrl_kill;

  // A load in EX/MEM has no data yet; the hazard unit stalls instead.
  assign exmem_src_ok = o_valid & o_wb_en & ~o_mem_read & (o_rd != 5'd0);
  assign wb_src_ok    = i_wb_en & (i_wb_rd != 5'd0);

  always_comb begin
    fwd_rs1 = i_rs1_val;
    if (exmem_src_ok && (o_rd == i_rs1)) begin
      fwd_rs1 = o_alu_result;
    end else if (wb_src_ok && (i_wb_rd == i_rs1)) begin
      fwd_rs1 = i_wb_data;
    end
  end

  always_comb begin
    fwd_rs2 = i_rs2_val;
    if (exmem_src_ok && (o_rd == i_rs2)) begin
      fwd_rs2 = o_alu_result;
    end else if (wb_src_ok && (i_wb_rd == i_rs2)) begin
      fwd_rs2 = i_wb_data;
    end
  end

  always_comb begin
    case (i_ctrl_op_a_sel)
      2'b00:   op_a = fwd_rs1;
      2'b01:   op_a = i_pc;
      default: op_a = '0;
    endcase
  end

  assign op_b  = i_ctrl_op_b_sel ? i_imm : fwd_rs2;
  assign shamt = op_b[4:0];

  always_comb begin
    case (i_ctrl_alu_op)
      ALU_ADD:   alu_out = op_a + op_b;
      ALU_SUB:   alu_out = op_a - op_b;
      ALU_SLL:   alu_out = op_a << shamt;
      ALU_SLT:   alu_out = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU:  alu_out = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_XOR:   alu_out = op_a ^ op_b;
      ALU_SRL:   alu_out = op_a >> shamt;
      ALU_SRA:   alu_out = $signed(op_a) >>> shamt;
      ALU_OR:    alu_out = op_a | op_b;
      ALU_AND:   alu_out = op_a & op_b;
      ALU_PASSB: alu_out = op_b;
      default:   alu_out = '0;
    endcase
  end

  always_comb begin
    case (i_ctrl_funct3)
      3'b000:  cond = (fwd_rs1 == fwd_rs2);
      3'b001:  cond = (fwd_rs1 != fwd_rs2);
      3'b100:  cond = ($signed(fwd_rs1) < $signed(fwd_rs2));
      3'b101:  cond = ($signed(fwd_rs1) >= $signed(fwd_rs2));
      3'b110:  cond = (fwd_rs1 < fwd_rs2);
      3'b111:  cond = (fwd_rs1 >= fwd_rs2);
      default: cond = 1'b0;
    endcase
  end

  assign branch_target = i_pc + i_imm;
  assign jump_target   = {alu_out[XLEN-1:1], 1'b0};
  // Jumps write the link address instead of the computed target.
  assign result        = i_ctrl_jump ? (i_pc + XLEN'(4)) : alu_out;

  assign take = live & (i_ctrl_jump | (i_ctrl_branch & cond));

  // A held instruction fires only on the cycle it is released, which is
  // the cycle it leaves EX, so each instruction redirects at most once.
  assign o_redirect    = i_reset & take & ~i_stall & ~i_flush;
  assign o_redirect_pc = i_ctrl_jump ? jump_target : branch_target;

  always_ff @(posedge i_clk) begin
    if (!i_reset || i_flush) begin
      o_valid      <= 1'b0;
      o_wb_en      <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_pc         <= '0;
      o_alu_result <= '0;
      o_store_data <= '0;
      o_rd         <= '0;
      o_funct3     <= '0;
    end else if (!i_stall) begin
      o_valid      <= live;
      o_wb_en      <= live & i_ctrl_wb_en;
      o_mem_read   <= live & i_ctrl_mem_read;
      o_mem_write  <= live & i_ctrl_mem_write;
      o_pc         <= i_pc;
      o_alu_result <= result;
      o_store_data <= fwd_rs2;
      o_rd         <= i_rd;
      o_funct3     <= i_ctrl_funct3;
    end
  end

endmodule
`default_nettype wire

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RV32I pipeline. It consumes the ID/EX pipeline register outputs directly.
- It performs operand forwarding, the ALU operation, branch/jump resolution and redirect generation.
- It latches results into its own EX/MEM register, which feeds the memory stage.
- Not-taken static prediction: every taken branch or jump raises a one-cycle redirect to fetch.

Parameters:
- XLEN, 32, datapath width.
- RESET_PC_ZERO, 1, reserved; EX/MEM outputs reset to zero regardless.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-low reset
- i_stall  in  1  hold EX/MEM register; suppress redirect
- i_flush  in  1  load bubble into EX/MEM register; suppress redirect
- i_pc, i_rs1_val, i_rs2_val, i_imm  in  32 each  from ID/EX
- i_rs1, i_rs2, i_rd  in  5 each  from ID/EX
- i_ctrl_valid, i_ctrl_bubble, i_ctrl_kill  in  1 each  from ID/EX
- i_ctrl_branch, i_ctrl_jump  in  1 each  from ID/EX
- i_ctrl_mem_read, i_ctrl_mem_write, i_ctrl_wb_en  in  1 each  from ID/EX
- i_ctrl_alu_op  in  4  from ID/EX
- i_ctrl_funct3  in  3  from ID/EX
- i_ctrl_op_a_sel  in  2  00 rs1, 01 pc, 10/11 zero
- i_ctrl_op_b_sel  in  1  0 rs2, 1 imm
- i_wb_en  in  1  MEM/WB writeback enable
- i_wb_rd  in  5  MEM/WB destination register
- i_wb_data  in  32  MEM/WB writeback data
- o_redirect  out  1  taken control transfer this cycle
- o_redirect_pc  out  32  redirect target
- o_pc, o_alu_result, o_store_data  out  32 each  EX/MEM register
- o_rd  out  5  EX/MEM register
- o_valid, o_wb_en, o_mem_read, o_mem_write  out  1 each  EX/MEM register
- o_funct3  out  3  EX/MEM register

Behaviour:
- live = i_ctrl_valid & !i_ctrl_bubble & !i_ctrl_kill.
- Forwarding (combinational), applied separately to rs1 and rs2:
  - First priority: EX/MEM, when o_valid & o_wb_en & !o_mem_read & o_rd!=0 & o_rd==rsX. Value is o_alu_result.
  - Second priority: MEM/WB, when i_wb_en & i_wb_rd!=0 & i_wb_rd==rsX. Value is i_wb_data.
  - Otherwise: i_rsX_val.
  - Load-use hazards are the hazard unit's responsibility (it stalls); no forwarding from a load in EX/MEM.
- Operand A: fwd_rs1 / i_pc / 0 per op_a_sel.
- Operand B: fwd_rs2 / i_imm per op_b_sel.
- ALU ops, 32-bit, wrap-around, no flags. Shift amount is B[4:0].
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
  - 11-15 produce 0.
- Branch compare uses fwd_rs1 vs fwd_rs2, selected by funct3:
  - 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010/011 give not-taken.
- Targets and result:
  - Branch target = i_pc + i_imm.
  - Jump target = ALU result with bit0 cleared; decode sets ADD with A=pc for JAL, A=rs1 for JALR.
  - Jump result = i_pc + 4, replacing the ALU result.
- take = live & (jump | (branch & cond)).
- o_redirect = take & !i_stall & !i_flush.
  - Combinational, same cycle.
  - Pulses exactly once per instruction even if the instruction is held several cycles.
- o_redirect_pc = jump ? jump target : branch target. Value is don't-care when o_redirect=0.
- EX/MEM register update at posedge, in priority order:
  - !i_reset: all outputs 0.
  - Else i_flush: o_valid=0, o_wb_en=0, o_mem_read=0, o_mem_write=0, all data fields 0.
  - Else i_stall: hold all outputs.
  - Else capture:
    - o_valid = live.
    - o_wb_en = live & i_ctrl_wb_en.
    - o_mem_read = live & i_ctrl_mem_read.
    - o_mem_write = live & i_ctrl_mem_write.
    - o_alu_result = result; o_store_data = fwd_rs2.
    - o_pc, o_rd, o_funct3 pass through.
- Flush and stall together: flush wins.
- Reset mid-stall: reset wins; no redirect while reset is low.
- A bubble or kill entering EX produces no side effects and no redirect.
- Latency: 1 cycle from the ID/EX outputs to the EX/MEM outputs; redirect has 0 latency.

Test Plan:
- ADD back-to-back: x1=5, x2=7, ADD x3; then ADD x4=x3+x3 with stale i_rs1_val=0 -> first o_alu_result=12; second o_alu_result=24 (EX/MEM forward).
- WB forward vs EX/MEM priority: i_wb_rd=3, i_wb_data=9 and o_rd=3 holding 24 -> rs1=3 uses 24; after clearing the EX/MEM match, rs1 uses 9. rd=0 is never forwarded.
- BNE x1=5, x2=7, pc=0x100, imm=0x20 -> o_redirect=1 for exactly one cycle, o_redirect_pc=0x120; with i_stall held 3 cycles the redirect stays 0 until release, then fires once.
- JALR: rs1=0x203, imm=4, pc=0x40 -> o_redirect_pc=0x206, o_alu_result=0x44, o_wb_en=1.
- Bubble or kill input with branch=1, mem_write=1 -> o_redirect=0; next cycle o_valid=0, o_mem_write=0, o_wb_en=0.
- SRA 0x80000000 by 4 gives 0xF8000000; SLT -1<1 gives 1, SLTU gives 0. With i_flush=i_stall=1: outputs go to the bubble state. With i_reset=0: all outputs are 0 next edge.
